axi_slave_mem: RTL and testbench

//  AXI4 slave/responder with internal word-addressed memory; the far end of the master driven via the user_req_* side.

---
 rtl/axi_slave_mem.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_axi_slave_mem.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_mem.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | axi_slave_mem : AXI4 responder backed by a word-addressed internal RAM     |
// | Revision      : 1.0                                                        |
// +-----------------------------------------------------------------------------+

`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_LEN_WIDTH
`define AXI_LEN_WIDTH 8
`endif
`ifndef AXI_SIZE_WIDTH
`define AXI_SIZE_WIDTH 3
`endif
`ifndef AXI_BURST_WIDTH
`define AXI_BURST_WIDTH 2
`endif

module axi_slave_mem #(
    parameter int ID_WIDTH    = `AXI_ID_WIDTH,
    parameter int ADDR_WIDTH  = `AXI_ADDR_WIDTH,
    parameter int DATA_WIDTH  = `AXI_DATA_WIDTH,
    parameter int LEN_WIDTH   = `AXI_LEN_WIDTH,
    parameter int SIZE_WIDTH  = `AXI_SIZE_WIDTH,
    parameter int BURST_WIDTH = `AXI_BURST_WIDTH,
    parameter int MEM_DEPTH   = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [LEN_WIDTH-1:0]    awlen,
    input  logic [SIZE_WIDTH-1:0]   awsize,
    input  logic [BURST_WIDTH-1:0]  awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [LEN_WIDTH-1:0]    arlen,
    input  logic [SIZE_WIDTH-1:0]   arsize,
    input  logic [BURST_WIDTH-1:0]  arburst,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFFS  = $clog2(BYTES);
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [BURST_WIDTH-1:0] BURST_FIXED = BURST_WIDTH'(0);
    localparam logic [BURST_WIDTH-1:0] BURST_WRAP  = BURST_WIDTH'(2);
    localparam logic [BURST_WIDTH-1:0] BURST_RSVD  = BURST_WIDTH'(3);
    localparam logic [1:0]             RESP_OKAY   = 2'b00;
    localparam logic [1:0]             RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
    typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    function automatic logic wrap_len_ok(input logic [LEN_WIDTH-1:0] len);
        return (len == LEN_WIDTH'(1)) || (len == LEN_WIDTH'(3)) ||
               (len == LEN_WIDTH'(7)) || (len == LEN_WIDTH'(15));
    endfunction

    function automatic logic burst_err(input logic [SIZE_WIDTH-1:0]  size,
                                       input logic [LEN_WIDTH-1:0]   len,
                                       input logic [BURST_WIDTH-1:0] burst);
        return (size > SIZE_WIDTH'(OFFS)) || (burst == BURST_RSVD) ||
               ((burst == BURST_WRAP) && !wrap_len_ok(len));
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0]  addr,
                                                        input logic [SIZE_WIDTH-1:0]  size,
                                                        input logic [LEN_WIDTH-1:0]   len,
                                                        input logic [BURST_WIDTH-1:0] burst);
        logic [ADDR_WIDTH-1:0] incr;
        logic [ADDR_WIDTH-1:0] bound;
        incr  = ADDR_WIDTH'(1) << size;
        bound = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) * incr;
        if (burst == BURST_FIXED)
            return addr;
        else if ((burst == BURST_WRAP) && wrap_len_ok(len))
            return (addr & ~(bound - ADDR_WIDTH'(1))) | ((addr + incr) & (bound - ADDR_WIDTH'(1)));
        else
            return addr + incr;
    endfunction

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
        return (addr >> OFFS) < ADDR_WIDTH'(MEM_DEPTH);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
        return addr[OFFS +: IDX_W];
    endfunction

    // ---------------- write path ----------------
    w_state_t               r_wstate;
    logic [ID_WIDTH-1:0]    r_wid;
    logic [ADDR_WIDTH-1:0]  r_waddr;
    logic [LEN_WIDTH-1:0]   r_wlen;
    logic [LEN_WIDTH-1:0]   r_wcnt;
    logic [SIZE_WIDTH-1:0]  r_wsize;
    logic [BURST_WIDTH-1:0] r_wburst;
    logic                   r_werr;

    logic w_wbeat;
    logic w_wfinal;
    logic w_werr_next;

    assign w_wbeat     = (r_wstate == W_DATA) && wvalid && wready;
    assign w_wfinal    = (r_wcnt == r_wlen);
    assign w_werr_next = r_werr || !in_range(r_waddr) || (wlast != w_wfinal);

    always_ff @(posedge clk) begin
        if (w_wbeat && in_range(r_waddr)) begin
            for (int i = 0; i < BYTES; i++) begin
                if (wstrb[i])
                    mem[word_idx(r_waddr)][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wstate <= W_IDLE;
            awready  <= 1'b0;
            wready   <= 1'b0;
            bvalid   <= 1'b0;
            bid      <= '0;
            bresp    <= RESP_OKAY;
            r_wid    <= '0;
            r_waddr  <= '0;
            r_wlen   <= '0;
            r_wcnt   <= '0;
            r_wsize  <= '0;
            r_wburst <= '0;
            r_werr   <= 1'b0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (awvalid && awready) begin
                        awready  <= 1'b0;
                        wready   <= 1'b1;
                        r_wid    <= awid;
                        r_waddr  <= awaddr;
                        r_wlen   <= awlen;
                        r_wsize  <= awsize;
                        r_wburst <= awburst;
                        r_wcnt   <= '0;
                        r_werr   <= burst_err(awsize, awlen, awburst);
                        r_wstate <= W_DATA;
                    end else begin
                        awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    // Length counter, not wlast, decides the end; wlast only grades the burst.
                    if (w_wbeat) begin
                        r_werr  <= w_werr_next;
                        r_waddr <= next_addr(r_waddr, r_wsize, r_wlen, r_wburst);
                        r_wcnt  <= r_wcnt + LEN_WIDTH'(1);
                        if (w_wfinal) begin
                            wready   <= 1'b0;
                            bvalid   <= 1'b1;
                            bid      <= r_wid;
                            bresp    <= w_werr_next ? RESP_SLVERR : RESP_OKAY;
                            r_wstate <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bvalid && bready) begin
                        bvalid   <= 1'b0;
                        awready  <= 1'b1;
                        r_wstate <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // ---------------- read path ----------------
    r_state_t               r_rstate;
    logic [ADDR_WIDTH-1:0]  r_raddr;
    logic [LEN_WIDTH-1:0]   r_rlen;
    logic [LEN_WIDTH-1:0]   r_rcnt;
    logic [SIZE_WIDTH-1:0]  r_rsize;
    logic [BURST_WIDTH-1:0] r_rburst;
    logic                   r_rerr;

    logic [LEN_WIDTH-1:0] w_rcnt_next;
    logic                 w_ar_err;

    assign w_rcnt_next = r_rcnt + LEN_WIDTH'(1);
    assign w_ar_err    = burst_err(arsize, arlen, arburst);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rstate <= R_IDLE;
            arready  <= 1'b0;
            rvalid   <= 1'b0;
            rlast    <= 1'b0;
            rid      <= '0;
            rdata    <= '0;
            rresp    <= RESP_OKAY;
            r_raddr  <= '0;
            r_rlen   <= '0;
            r_rcnt   <= '0;
            r_rsize  <= '0;
            r_rburst <= '0;
            r_rerr   <= 1'b0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (arvalid && arready) begin
                        arready  <= 1'b0;
                        rvalid   <= 1'b1;
                        rid      <= arid;
                        r_rlen   <= arlen;
                        r_rsize  <= arsize;
                        r_rburst <= arburst;
                        r_rcnt   <= '0;
                        r_rerr   <= w_ar_err;
                        rdata    <= in_range(araddr) ? mem[word_idx(araddr)] : '0;
                        rresp    <= (!in_range(araddr) || w_ar_err) ? RESP_SLVERR : RESP_OKAY;
                        rlast    <= (arlen == '0);
                        r_raddr  <= next_addr(araddr, arsize, arlen, arburst);
                        r_rstate <= R_DATA;
                    end else begin
                        arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (rvalid && rready) begin
                        if (rlast) begin
                            rvalid   <= 1'b0;
                            rlast    <= 1'b0;
                            arready  <= 1'b1;
                            r_rstate <= R_IDLE;
                        end else begin
                            rdata   <= in_range(r_raddr) ? mem[word_idx(r_raddr)] : '0;
                            rresp   <= (!in_range(r_raddr) || r_rerr) ? RESP_SLVERR : RESP_OKAY;
                            rlast   <= (w_rcnt_next == r_rlen);
                            r_rcnt  <= w_rcnt_next;
                            r_raddr <= next_addr(r_raddr, r_rsize, r_rlen, r_rburst);
                        end
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axi_slave_mem.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_axi_slave_mem : directed self-checking bench for axi_slave_mem          |
// | Revision         : 1.0                                                     |
// +-----------------------------------------------------------------------------+
module tb_axi_slave_mem;

    localparam int ID_W  = 4;
    localparam int ADR_W = 32;
    localparam int DAT_W = 32;
    localparam int DEPTH = 1024;

    logic              clk;
    logic              rst_n;
    logic [ID_W-1:0]   awid,  arid,  bid,  rid;
    logic [ADR_W-1:0]  awaddr, araddr;
    logic [7:0]        awlen, arlen;
    logic [2:0]        awsize, arsize;
    logic [1:0]        awburst, arburst, bresp, rresp;
    logic              awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic              arvalid, arready, rlast, rvalid, rready;
    logic [DAT_W-1:0]  wdata, rdata;
    logic [DAT_W/8-1:0] wstrb;

    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic [31:0] ed [16];

    int n_checks = 0;
    int n_pass   = 0;

    axi_slave_mem #(
        .ID_WIDTH(ID_W), .ADDR_WIDTH(ADR_W), .DATA_WIDTH(DAT_W),
        .LEN_WIDTH(8), .SIZE_WIDTH(3), .BURST_WIDTH(2), .MEM_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int last_beat,
                            input logic [1:0] exp_resp, input string tag);
        int n;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 100) begin @(posedge clk); #1; n++; end
        check_eq({tag, "_aw_timeout"}, n >= 100, 0);
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wdata  = wd[i];
            wstrb  = ws[i];
            wlast  = (last_beat < 0) ? (i == int'(len)) : (i == last_beat);
            wvalid = 1'b1;
            n = 0;
            while (!wready && n < 100) begin @(posedge clk); #1; n++; end
            @(posedge clk); #1;
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        check_eq({tag, "_bvalid_lat"}, bvalid, 1);
        n = 0;
        while (!bvalid && n < 100) begin @(posedge clk); #1; n++; end
        check_eq({tag, "_bid"}, bid, id);
        check_eq({tag, "_bresp"}, bresp, exp_resp);
        @(posedge clk); #1;
        check_eq({tag, "_b_done"}, {bvalid, awready}, 2'b01);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input bit toggle,
                           input logic [1:0] exp_resp, input string tag);
        int n, beats, cyc;
        bit ph;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 100) begin @(posedge clk); #1; n++; end
        check_eq({tag, "_ar_timeout"}, n >= 100, 0);
        @(posedge clk); #1;
        arvalid = 1'b0;
        check_eq({tag, "_rvalid_lat"}, rvalid, 1);
        beats = 0; cyc = 0; ph = 1'b0;
        while (beats <= int'(len) && cyc < 200) begin
            rready = toggle ? ph : 1'b1;
            ph = ~ph;
            if (rvalid) begin
                check_eq({tag, "_rdata"}, rdata, ed[beats]);
                check_eq({tag, "_rresp"}, rresp, exp_resp);
                check_eq({tag, "_rlast"}, rlast, beats == int'(len));
                check_eq({tag, "_rid"}, rid, id);
                if (rready) beats++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        rready = 1'b0;
        check_eq({tag, "_r_timeout"}, beats <= int'(len), 0);
        check_eq({tag, "_r_done"}, rvalid, 0);
        if (!toggle) check_eq({tag, "_r_cycles"}, cyc, int'(len) + 1);
    endtask

    initial begin
        rst_n = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b1;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        rready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ctrl", {awready, arready, wready, bvalid, rvalid, rlast}, 6'b0);
        check_eq("rst_data", {rdata, rid, bid, bresp, rresp}, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("rdy_after_rst", {awready, arready}, 2'b11);

        // basic INCR write then read back
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + i; ws[i] = 4'hF; ed[i] = 32'hA0 + i; end
        do_write(4'd3, 32'h10, 8'd3, 3'd2, 2'b01, -1, 2'b00, "t1_wr");
        do_read(4'd5, 32'h10, 8'd3, 3'd2, 2'b01, 1'b0, 2'b00, "t2_rd");

        // WRAP from 0x18: 0x18, 0x1C, 0x10, 0x14 with rready toggling
        ed[0] = 32'hA2; ed[1] = 32'hA3; ed[2] = 32'hA0; ed[3] = 32'hA1;
        do_read(4'd6, 32'h18, 8'd3, 3'd2, 2'b10, 1'b1, 2'b00, "t3_wrap");

        // out-of-range write must not alias onto word 0
        wd[0] = 32'h0; ws[0] = 4'hF;
        do_write(4'd1, 32'h0, 8'd0, 3'd2, 2'b01, -1, 2'b00, "t4_w0");
        wd[0] = 32'hFFFF_FFFF;
        do_write(4'd2, DEPTH * 4, 8'd0, 3'd2, 2'b01, -1, 2'b10, "t4_woor");
        ed[0] = 32'h0;
        do_read(4'd2, DEPTH * 4, 8'd0, 3'd2, 2'b01, 1'b0, 2'b10, "t4_roor");
        do_read(4'd2, 32'h0, 8'd0, 3'd2, 2'b01, 1'b0, 2'b00, "t4_w0_keep");

        // early wlast on beat 1 of a 3-beat burst: SLVERR, all beats still land
        for (int i = 0; i < 3; i++) begin wd[i] = 32'hC0 + i; ws[i] = 4'hF; ed[i] = 32'hC0 + i; end
        do_write(4'd4, 32'h40, 8'd2, 3'd2, 2'b01, 1, 2'b10, "t4_early");
        do_read(4'd4, 32'h40, 8'd2, 3'd2, 2'b01, 1'b0, 2'b00, "t4_early_rd");

        // byte strobes
        wd[0] = 32'hDEAD_BEEF; ws[0] = 4'b0101; ed[0] = 32'h00AD_00EF;
        do_write(4'd7, 32'h0, 8'd0, 3'd2, 2'b01, -1, 2'b00, "t5_strb");
        do_read(4'd7, 32'h0, 8'd0, 3'd2, 2'b01, 1'b0, 2'b00, "t5_strb_rd");

        // FIXED burst: only the last beat survives; FIXED read repeats it
        for (int i = 0; i < 4; i++) begin wd[i] = 32'h1 + i; ws[i] = 4'hF; end
        do_write(4'd8, 32'h20, 8'd3, 3'd2, 2'b00, -1, 2'b00, "t5_fixed");
        ed[0] = 32'h4; ed[1] = 32'h4;
        do_read(4'd8, 32'h20, 8'd1, 3'd2, 2'b00, 1'b0, 2'b00, "t5_fixed_rd");

        // reset in the middle of a read burst
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hB0 + i; ws[i] = 4'hF; end
        do_write(4'd9, 32'h30, 8'd3, 3'd2, 2'b01, -1, 2'b00, "t6_wr");
        arid = 4'hA; araddr = 32'h30; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
        begin
            int n;
            n = 0;
            while (!arready && n < 100) begin @(posedge clk); #1; n++; end
            check_eq("t6_ar_timeout", n >= 100, 0);
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        rready  = 1'b1;
        check_eq("t6_beat0", rdata, 32'hB0);
        @(posedge clk); #1;
        check_eq("t6_beat1", rdata, 32'hB1);
        @(posedge clk); #1;
        check_eq("t6_beat2", {rvalid, rdata}, {1'b1, 32'hB2});
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_outs", {rvalid, rlast, arready}, 3'b000);
        rready = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("t6_release", {arready, rvalid}, 2'b10);
        ed[0] = 32'hB0; ed[1] = 32'hB1;
        do_read(4'hB, 32'h30, 8'd1, 3'd2, 2'b01, 1'b0, 2'b00, "t6_after");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
